// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with grant hold and explicit release.
// Registered one-hot grant plus binary index; the served requester drops to lowest priority.
//
// state | meaning
// IDLE  | no grant; pick the next winner from req starting at ptr
// GRANT | holding grant_idx until release_i or the holder drops its request
module rr_arbiter16 #(
  parameter int N    = 16,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            release_i,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   ptr, ptr_nxt;
  logic [N-1:0]      grant_nxt;
  logic              valid_nxt;
  logic [IDXW-1:0]   idx_nxt;

  logic [2*N-1:0]    req_dbl;
  logic [N-1:0]      req_rot;
  logic [IDXW-1:0]   pick;
  logic [IDXW-1:0]   winner;
  logic              done;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    pick    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) pick = i[IDXW-1:0];
    end
    winner = ptr + pick;
  end

  // Release and withdrawal together count as one release event.
  assign done = release_i || !req[grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant       <= grant_nxt;
      grant_valid <= valid_nxt;
      grant_idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (|req) state_nxt = GRANT;
      end
      GRANT: begin
        if (done) begin
          state_nxt = IDLE;
          ptr_nxt   = grant_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = grant;
    valid_nxt = grant_valid;
    idx_nxt   = grant_idx;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = {{(N-1){1'b0}}, 1'b1} << winner;
          valid_nxt = 1'b1;
          idx_nxt   = winner;
        end
      end
      GRANT: begin
        if (done) begin
          grant_nxt = '0;
          valid_nxt = 1'b0;
          idx_nxt   = '0;
        end
      end
      default: begin
        grant_nxt = '0;
        valid_nxt = 1'b0;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: hand-computed grant sequences plus
// per-cycle invariant and encoder cross-checks.
module tb_rr_arbiter16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        release_i;
  logic [15:0] grant;
  logic        grant_valid;
  logic [3:0]  grant_idx;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  rr_arbiter16 dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .release_i   (release_i),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  // Reference one-hot to binary encoder (stands in for encoder16x4).
  function automatic logic [3:0] enc16(input logic [15:0] v);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] eg, input logic ev, input logic [3:0] ei);
    vectors++;
    assert (grant === eg && grant_valid === ev && grant_idx === ei) else begin
      miscompares++;
      $error("FAIL %s: got grant=%h valid=%b idx=%0d, expected grant=%h valid=%b idx=%0d",
             tag, grant, grant_valid, grant_idx, eg, ev, ei);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] ei);
    chk(tag, 16'h0001 << ei, 1'b1, ei);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 16'h0000, 1'b0, 4'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      assert ($onehot0(grant) && grant_valid === |grant &&
              grant === (grant_valid ? (16'h0001 << grant_idx) : 16'h0000) &&
              (!grant_valid || enc16(grant) === grant_idx)) else begin
        miscompares++;
        $error("FAIL invariant: got grant=%h valid=%b idx=%0d, expected consistent one-hot/index",
               grant, grant_valid, grant_idx);
      end
    end
  end

  initial begin
    rst = 1'b1; req = 16'h0000; release_i = 1'b0;
    tick(); tick();
    mon_en = 1'b1;
    chk_idle("reset");
    rst = 1'b0;

    req = 16'h0001;
    tick(); chk_grant("single_req0", 4'd0);
    req = 16'hFFFF;
    tick(); chk_grant("hold0", 4'd0);

    for (int k = 1; k <= 16; k++) begin
      release_i = 1'b1;
      tick(); release_i = 1'b0;
      chk_idle($sformatf("rr_gap%0d", k));
      tick(); chk_grant($sformatf("rr_grant%0d", k), 4'(k % 16));
    end

    release_i = 1'b1; req = 16'h8000;
    tick(); release_i = 1'b0; chk_idle("to15_gap");
    tick(); chk_grant("grant15", 4'd15);
    release_i = 1'b1; req = 16'h8001;
    tick(); release_i = 1'b0; chk_idle("wrap_gap");
    tick(); chk_grant("wrap_to0", 4'd0);
    release_i = 1'b1;
    tick(); release_i = 1'b0; chk_idle("gap_0_15");
    tick(); chk_grant("after0_15", 4'd15);

    release_i = 1'b1; req = 16'h0000;
    tick(); release_i = 1'b0; chk_idle("rel_and_drop");
    tick(); chk_idle("idle_noreq");
    release_i = 1'b1;
    tick(); release_i = 1'b0; chk_idle("rel_in_idle");
    req = 16'h0003;
    tick(); chk_grant("ptr_once", 4'd0);

    release_i = 1'b1; req = 16'h0060;
    tick(); release_i = 1'b0; chk_idle("gap_to5");
    tick(); chk_grant("grant5", 4'd5);
    req = 16'h0040;
    tick(); chk_idle("withdraw5");
    tick(); chk_grant("grant6", 4'd6);

    release_i = 1'b1; req = 16'h0200;
    tick(); release_i = 1'b0; chk_idle("gap_to9");
    tick(); chk_grant("grant9", 4'd9);
    rst = 1'b1; req = 16'h0210;
    tick(); chk_idle("rst_midgrant");
    rst = 1'b0;
    tick(); chk_grant("ptr_reset", 4'd4);
    req = 16'hFFFF;
    tick(); chk_grant("hold4_others", 4'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
